udp_tx_packer: RTL and testbench

- Transmit-side companion to the UDP receive FIFO.
- The host side writes 32-bit words into an internal buffer of HANG_LEN words.
- On a send request, the block starts one UDP packet and serializes the words MSB-byte-first into the UDP core's byte request/data interface.
- Sits between the host bus (hclk) and the UDP core's tx_req/tx_data/tx_start_en/udp_tx_done/tx_byte_num ports; replaces the fixed 4-byte 0x21 payload.

---
 rtl/udp_tx_packer.sv | 139 +++++++++++++
 tb/tb_udp_tx_packer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_packer.sv
// Host word buffer serialized MSB-byte-first into the UDP core tx port.
// Build option UDP_TX_PAD_EN pads short packets to an 18-byte payload.
module udp_tx_packer #(
  parameter int HANG_LEN    = 256,
  parameter int HANG_LEN_B  = 8,
  parameter int SRAM_DATA_W = 32
) (
  input  logic                   hclk,
  input  logic                   sys_rst,
  input  logic [SRAM_DATA_W-1:0] fifo_data_in,
  input  logic                   fifo_write,
  input  logic                   send_req,
  input  logic                   tx_req,
  input  logic                   udp_tx_done,
  output logic [7:0]             tx_data,
  output logic [15:0]            tx_byte_num,
  output logic                   tx_start_en,
  output logic                   busy,
  output logic [HANG_LEN_B:0]    word_count,
  output logic                   buffer_full,
  output logic                   write_overflow,
  output logic                   Send_done
);

  localparam int PW = HANG_LEN_B + 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SEND
  } state_t;

  state_t state, state_nx;

  logic [SRAM_DATA_W-1:0] mem [HANG_LEN];
  logic [SRAM_DATA_W-1:0] rd_word;
  logic [1:0]             rd_sel;
  logic                   rd_zero;
  logic [PW-1:0]          ptr;
  logic [HANG_LEN_B:0]    count_nx;
  logic [15:0]            bytes_nx;
  logic [15:0]            len_nx;
  logic                   wr_en;
  logic                   go;
  logic                   done;
  logic                   rd_en;
  logic                   done_q;

  assign buffer_full = word_count == (HANG_LEN_B+1)'(HANG_LEN);
  assign wr_en    = state == IDLE && fifo_write && !buffer_full;
  assign count_nx = word_count + {{HANG_LEN_B{1'b0}}, wr_en};
  assign bytes_nx = {{(16-PW){1'b0}}, count_nx, 2'b00};
  assign go       = state == IDLE && send_req && count_nx != '0;
  assign done     = state == SEND && udp_tx_done;
  assign rd_en    = state == SEND && tx_req;

`ifdef UDP_TX_PAD_EN
  // short packets grow to the minimum Ethernet payload
  assign len_nx = (bytes_nx < 16'd18) ? 16'd18 : bytes_nx;
`else
  assign len_nx = bytes_nx;
`endif

  always_ff @(posedge hclk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (go) state_nx = START;
      START:   state_nx = SEND;
      SEND:    if (udp_tx_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx_start_en = 1'b0;
    busy        = 1'b0;
    unique case (state)
      START: begin
        tx_start_en = 1'b1;
        busy        = 1'b1;
      end
      SEND:    busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (sys_rst) begin
      word_count     <= '0;
      write_overflow <= 1'b0;
      tx_byte_num    <= '0;
      ptr            <= '0;
      rd_sel         <= '0;
      rd_zero        <= 1'b1;
      done_q         <= 1'b0;
    end else begin
      done_q <= done;
      if (done)       word_count <= '0;
      else if (wr_en) word_count <= count_nx;
      if (fifo_write && !wr_en) write_overflow <= 1'b1;
      else if (go)              write_overflow <= 1'b0;
      if (go) tx_byte_num <= len_nx;
      // pointer parks at the packet length once all bytes are served
      if (state == START)
        ptr <= '0;
      else if (rd_en && {{(16-PW){1'b0}}, ptr} != tx_byte_num)
        ptr <= ptr + 1'b1;
      if (rd_en) begin
        rd_sel  <= ptr[1:0];
        rd_zero <= ptr >= {word_count, 2'b00};
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (wr_en) mem[word_count[HANG_LEN_B-1:0]] <= fifo_data_in;
    if (rd_en) rd_word <= mem[ptr[HANG_LEN_B+1:2]];
  end

  always_comb begin
    tx_data = '0;
    if (!rd_zero) begin
      unique case (rd_sel)
        2'd0:    tx_data = rd_word[31:24];
        2'd1:    tx_data = rd_word[23:16];
        2'd2:    tx_data = rd_word[15:8];
        default: tx_data = rd_word[7:0];
      endcase
    end
  end

  assign Send_done = done_q;

endmodule

// File: tb/tb_udp_tx_packer.sv
// Scoreboard bench for udp_tx_packer.
// Expected bytes are queued on each tx_req and popped one cycle later.
module tb_udp_tx_packer;

  logic        hclk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] fifo_data_in = '0;
  logic        fifo_write = 1'b0;
  logic        send_req = 1'b0;
  logic        tx_req = 1'b0;
  logic        udp_tx_done = 1'b0;
  logic [7:0]  tx_data;
  logic [15:0] tx_byte_num;
  logic        tx_start_en;
  logic        busy;
  logic [8:0]  word_count;
  logic        buffer_full;
  logic        write_overflow;
  logic        Send_done;

  udp_tx_packer dut (
    .hclk           (hclk),
    .sys_rst        (sys_rst),
    .fifo_data_in   (fifo_data_in),
    .fifo_write     (fifo_write),
    .send_req       (send_req),
    .tx_req         (tx_req),
    .udp_tx_done    (udp_tx_done),
    .tx_data        (tx_data),
    .tx_byte_num    (tx_byte_num),
    .tx_start_en    (tx_start_en),
    .busy           (busy),
    .word_count     (word_count),
    .buffer_full    (buffer_full),
    .write_overflow (write_overflow),
    .Send_done      (Send_done)
  );

  always #5 hclk = ~hclk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mw [256];
  int          mcnt = 0;
  int          bptr = 0;
  int          cur_len = 0;
  logic [7:0]  sb [$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  function automatic int plen(input int n);
    int b;
    b = n * 4;
`ifdef UDP_TX_PAD_EN
    if (b < 18) b = 18;
`endif
    return b;
  endfunction

  function automatic logic [7:0] exp_byte(input int p);
    logic [31:0] w;
    if (p >= mcnt * 4) return 8'h00;
    w = mw[p/4] >> (8 * (3 - p % 4));
    return w[7:0];
  endfunction

  task automatic write_word(input logic [31:0] w);
    fifo_data_in = w;
    fifo_write   = 1'b1;
    if (mcnt < 256) begin
      mw[mcnt] = w;
      mcnt++;
    end
    tick();
    fifo_write = 1'b0;
  endtask

  task automatic start_send(input int n);
    send_req = 1'b1;
    tick();
    send_req   = 1'b0;
    fifo_write = 1'b0;
    chk("start_pulse", tx_start_en, 1);
    chk("busy_start", busy, 1);
    chk("byte_num", tx_byte_num, plen(n));
    chk("ovf_clear", write_overflow, 0);
    tick();
    chk("start_once", tx_start_en, 0);
    bptr    = 0;
    cur_len = plen(n);
  endtask

  task automatic serve(input int n, input bit gap);
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      tx_req = 1'b1;
      sb.push_back(exp_byte(bptr));
      if (bptr < cur_len) bptr++;
      tick();
      e = sb.pop_front();
      chk("byte", tx_data, e);
      if (gap) begin
        tx_req = 1'b0;
        tick();
        chk("hold", tx_data, e);
      end
    end
    tx_req = 1'b0;
  endtask

  task automatic finish_pkt();
    udp_tx_done = 1'b1;
    tick();
    udp_tx_done = 1'b0;
    chk("send_done", Send_done, 1);
    chk("wc_clear", word_count, 0);
    chk("busy_done", busy, 0);
    tick();
    chk("done_once", Send_done, 0);
    mcnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    sys_rst = 1'b0;
    tick();
    chk("rst_data", tx_data, 0);
    chk("rst_len", tx_byte_num, 0);
    chk("rst_start", tx_start_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_full", buffer_full, 0);
    chk("rst_ovf", write_overflow, 0);
    chk("rst_done", Send_done, 0);

    write_word(32'h11223344);
    write_word(32'h55667788);
    chk("wc2", word_count, 2);
    start_send(2);
    serve(8, 1'b0);
    finish_pkt();

    for (int i = 0; i < 256; i++)
      write_word($urandom);
    chk("full", buffer_full, 1);
    chk("wc256", word_count, 256);
    chk("no_ovf", write_overflow, 0);
    write_word(32'hFFFF0000);
    chk("ovf_full", write_overflow, 1);
    chk("wc_hold", word_count, 256);
    start_send(256);
    serve(1024, 1'b0);
    serve(1, 1'b0);
    finish_pkt();

    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    chk("empty_start", tx_start_en, 0);
    chk("empty_busy", busy, 0);
    tick();
    chk("empty_busy2", busy, 0);

    write_word(32'hDEADBEEF);
    start_send(1);
    serve(6, 1'b1);
    finish_pkt();

    write_word(32'h01020304);
    write_word(32'hA0B0C0D0);
    start_send(2);
    fifo_data_in = 32'hBAD0BAD0;
    fifo_write   = 1'b1;
    tick();
    fifo_write = 1'b0;
    chk("ovf_send", write_overflow, 1);
    chk("wc_send", word_count, 2);
    serve(8, 1'b1);
    finish_pkt();
    write_word(32'hCAFEF00D);
    chk("ovf_sticky", write_overflow, 1);
    start_send(1);
    serve(4, 1'b0);
    finish_pkt();

    write_word(32'h0A0B0C0D);
    write_word(32'h1A1B1C1D);
    start_send(2);
    serve(3, 1'b0);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    mcnt = 0;
    chk("mid_busy", busy, 0);
    chk("mid_wc", word_count, 0);
    chk("mid_data", tx_data, 0);
    udp_tx_done = 1'b1;
    tick();
    udp_tx_done = 1'b0;
    chk("mid_nodone", Send_done, 0);
    tick();
    chk("mid_nodone2", Send_done, 0);

    write_word(32'h31323334);
    fifo_data_in = 32'h41424344;
    fifo_write   = 1'b1;
    mw[mcnt]     = 32'h41424344;
    mcnt++;
    start_send(2);
    chk("same_wc", word_count, 2);
    serve(8, 1'b0);
    finish_pkt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
